periph_timer: RTL
=================

PERIPH_TIMER -- requirements
Module: periph_timer

Interface
REQ-001 Parameter PERIPH_DATA_WIDTH, default 32: width of io_data and of the LOAD and COUNT registers.
REQ-002 Parameter PERIPH_ADDR_WIDTH, default 6: width of io_addr, which is a register index, not a byte address.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port io_addr  input  PERIPH_ADDR_WIDTH: register index from the I/O slot.
REQ-006 Port io_data  inout  PERIPH_DATA_WIDTH: write data in; read data out.
REQ-007 Port io_read  input  1: read strobe, level, held until io_ready is seen.
REQ-008 Port io_write  input  1: write strobe, level, held until io_ready is seen.
REQ-009 Port io_ready  output  1: access acknowledge.
REQ-010 Port irq  output  1: timer interrupt request, level.

Function
REQ-011 Register map:
  - 0 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE; other bits read 0.
  - 1 LOAD: reload value.
  - 2 COUNT: read-only.
  - 3 STATUS: bit0 EXP, sticky; write 1 to clear.
  - 4 PRESC: bits[7:0], prescale divisor minus 1.
REQ-012 Unmapped indices shall read 0, ignore writes, and still acknowledge.
REQ-013 Bus FSM states:
  - IDLE to ACK when io_read or io_write is high.
  - ACK to HOLD unconditionally.
  - HOLD to IDLE when io_read and io_write are both low.
REQ-014 io_ready shall be 1 in ACK and HOLD, 0 in IDLE, giving one cycle of latency from strobe to ready.
REQ-015 A write shall commit exactly once, on the IDLE-to-ACK edge; holding io_write longer shall not re-commit.
REQ-016 Read data shall be sampled on the IDLE-to-ACK edge into a holding register.
REQ-017 io_data shall be driven from that register only while io_read is 1 and the FSM is in ACK or HOLD; otherwise io_data is high-Z.
REQ-018 If io_read and io_write are both high in IDLE, the read shall take priority and no write commits.
REQ-019 Prescaler:
  - 8-bit counter, active only while EN is 1.
  - Increments each cycle; a tick occurs when it equals PRESC, and it then returns to 0.
  - PRESC = 0 means a tick every cycle.
REQ-020 On a tick with COUNT != 0, COUNT shall decrement by 1.
REQ-021 On a tick with COUNT = 0:
  - EXP shall be set.
  - If AUTO = 1, COUNT shall be set to LOAD.
  - If AUTO = 0, EN shall clear and COUNT shall stay 0.
REQ-022 Writing LOAD shall also copy the value into COUNT and clear the prescaler, in the same cycle, regardless of EN.
REQ-023 Writing CTRL with EN rising 0 to 1 shall clear the prescaler; COUNT is unchanged.
REQ-024 If a STATUS write-1-clear and an expiry occur in the same cycle, EXP shall end at 1 (set wins).
REQ-025 If a LOAD write and a tick occur in the same cycle, the LOAD write wins and no decrement or expiry occurs that cycle.
REQ-026 irq shall equal EXP AND IE, driven combinationally from registers.
REQ-027 COUNT arithmetic shall be unsigned, PERIPH_DATA_WIDTH bits, with no wrap below 0 (per REQ-021).

Reset
REQ-028 While rst_n = 0, the following shall be forced immediately, without waiting for clk:
  - FSM to IDLE; io_ready = 0; io_data high-Z; irq = 0.
  - CTRL, LOAD, COUNT, STATUS, PRESC, the prescaler and the read holding register all 0.
REQ-029 Reset asserted mid-access shall abort it: no write commits after reset, and the FSM restarts in IDLE after rst_n rises.

Verification
REQ-030 Write LOAD=5, PRESC=0, CTRL=0x1 -> COUNT reads 5,4,..,0 on successive ticks; EXP=1 one tick after 0; EN then reads 0 and COUNT stays 0.
REQ-031 LOAD=2, PRESC=3, CTRL=0x7 -> a tick every 4 cycles; irq rises 12 cycles after EN; COUNT reloads to 2 and keeps running.
REQ-032 io_write held for 5 cycles to LOAD=7 while the timer runs -> io_ready at cycle 2, single commit, COUNT=7 then decrements normally.
REQ-033 Read COUNT while it decrements -> io_data returns the value sampled at the IDLE-to-ACK edge and stays stable during HOLD; io_data is Z after io_read drops.
REQ-034 Write STATUS=1 in the same cycle as an expiry -> EXP remains 1 and irq stays high; a later STATUS=1 write clears it.
REQ-035 Assert rst_n=0 during an ACK of a CTRL write -> io_ready=0 and irq=0 asynchronously; CTRL reads 0 after release.

Source files
------------

// File: rtl/periph_timer.sv
// Countdown timer peripheral: 8-bit prescaler, auto-reload, sticky expiry.
// Register-indexed I/O slot with an IDLE/ACK/HOLD acknowledge handshake.
module periph_timer #(
    parameter int PERIPH_DATA_WIDTH = 32,
    parameter int PERIPH_ADDR_WIDTH = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PERIPH_ADDR_WIDTH-1:0] io_addr,
    inout  wire  [PERIPH_DATA_WIDTH-1:0] io_data,
    input  logic                         io_read,
    input  logic                         io_write,
    output logic                         io_ready,
    output logic                         irq
);
    localparam int DW = PERIPH_DATA_WIDTH;
    localparam int AW = PERIPH_ADDR_WIDTH;

    localparam logic [AW-1:0] A_CTRL   = AW'(0);
    localparam logic [AW-1:0] A_LOAD   = AW'(1);
    localparam logic [AW-1:0] A_COUNT  = AW'(2);
    localparam logic [AW-1:0] A_STATUS = AW'(3);
    localparam logic [AW-1:0] A_PRESC  = AW'(4);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_e;

    state_e        state_q;
    logic          ready_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rd_mux;

    logic          en_q, en_d;
    logic          auto_q, auto_d;
    logic          ie_q, ie_d;
    logic          exp_q, exp_d;
    logic [DW-1:0] load_q, load_d;
    logic [DW-1:0] count_q, count_d;
    logic [7:0]    presc_q, presc_d;
    logic [7:0]    pcnt_q, pcnt_d;

    logic access, wr;
    logic wr_ctrl, wr_load, wr_status, wr_presc;
    logic tick, expire;

    // A read beats a simultaneous write; only the IDLE->ACK edge commits.
    assign access    = (state_q == IDLE) && (io_read || io_write);
    assign wr        = access && io_write && !io_read;
    assign wr_ctrl   = wr && (io_addr == A_CTRL);
    assign wr_load   = wr && (io_addr == A_LOAD);
    assign wr_status = wr && (io_addr == A_STATUS);
    assign wr_presc  = wr && (io_addr == A_PRESC);

    assign tick   = en_q && (pcnt_q == presc_q);
    assign expire = tick && !wr_load && (count_q == '0);

    assign io_ready = ready_q;
    assign irq      = exp_q & ie_q;
    assign io_data  = (io_read && state_q != IDLE) ? rdata_q : 'z;

    always_comb begin
        rd_mux = '0;
        case (io_addr)
            A_CTRL:   rd_mux[2:0] = {ie_q, auto_q, en_q};
            A_LOAD:   rd_mux      = load_q;
            A_COUNT:  rd_mux      = count_q;
            A_STATUS: rd_mux[0]   = exp_q;
            A_PRESC:  rd_mux[7:0] = presc_q;
            default:  rd_mux      = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (io_read || io_write) begin
                    state_q <= ACK;
                    ready_q <= 1'b1;
                    rdata_q <= rd_mux;
                end
                ACK: begin
                    state_q <= HOLD;
                    ready_q <= 1'b1;
                end
                HOLD: if (!io_read && !io_write) begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        en_d    = en_q;
        auto_d  = auto_q;
        ie_d    = ie_q;
        exp_d   = exp_q;
        load_d  = load_q;
        count_d = count_q;
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        if (en_q) pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
        if (tick && !wr_load) begin
            if (count_q != '0) count_d = count_q - DW'(1);
            else if (auto_q)   count_d = load_q;
            else               en_d    = 1'b0;
        end
        // Expiry set wins over a same-cycle write-1-clear.
        if (wr_status && io_data[0]) exp_d = 1'b0;
        if (expire) exp_d = 1'b1;
        if (wr_ctrl) begin
            en_d   = io_data[0];
            auto_d = io_data[1];
            ie_d   = io_data[2];
            if (io_data[0] && !en_q) pcnt_d = 8'd0;
        end
        if (wr_load) begin
            load_d  = io_data;
            count_d = io_data;
            pcnt_d  = 8'd0;
        end
        if (wr_presc) presc_d = io_data[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            exp_q   <= 1'b0;
            load_q  <= '0;
            count_q <= '0;
            presc_q <= 8'd0;
            pcnt_q  <= 8'd0;
        end else begin
            en_q    <= en_d;
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            exp_q   <= exp_d;
            load_q  <= load_d;
            count_q <= count_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
endmodule
